aes_out_collector: RTL and testbench



---
 rtl/aes_out_collector.sv | 122 ++++++++++++
 tb/tb_aes_out_collector.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_out_collector.sv
// Deserialises the AES core's byte stream into 128-bit blocks queued in a small block FIFO.
// Block is visible one cycle after its last byte; the core never stalls, so a push into a full FIFO with no pop drops the block and raises a sticky overflow flag.
module aes_out_collector #(
    parameter int NBYTES = 16,
    parameter int BW     = 8,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BW-1:0]             d_in,
    input  logic                      d_vld,
    output logic [NBYTES*BW-1:0]      blk_out,
    output logic                      blk_vld,
    input  logic                      blk_rdy,
    output logic                      busy,
    output logic                      overflow,
    input  logic                      clr_ovf,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int W  = NBYTES * BW;
    localparam int CW = $clog2(NBYTES);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          state;
    logic [CW-1:0]   byte_cnt;
    logic            d_vld_q;
    // Holds bytes 0..NBYTES-2; the last byte is appended straight from d_in on push.
    logic [W-BW-1:0] shreg;

    logic            start;
    logic            push;
    logic            pop;
    logic            full;
    logic            accept;
    logic            ovf_evt;
    logic [W-1:0]    blk_dat;

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    assign start   = d_vld & ~d_vld_q;
    assign push    = (state == COLLECT) && (byte_cnt == CW'(NBYTES - 1));
    assign blk_dat = {shreg, d_in};

    assign full    = (level == LW'(DEPTH));
    assign blk_vld = (level != '0);
    assign pop     = blk_vld & blk_rdy;
    // A full FIFO still takes the new block when the head leaves in the same cycle.
    assign accept  = push & (~full | pop);
    assign ovf_evt = push & full & ~pop;
    assign blk_out = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            d_vld_q  <= 1'b0;
            shreg    <= '0;
            busy     <= 1'b0;
        end else begin
            d_vld_q <= d_vld;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= {{(W - 2*BW){1'b0}}, d_in};
                        byte_cnt <= CW'(1);
                        busy     <= 1'b1;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    shreg <= {shreg[W-2*BW-1:0], d_in};
                    if (push) begin
                        byte_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= blk_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(accept) - LW'(pop);
        end
    end

    // A new drop wins over a simultaneous clear so no event is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (ovf_evt) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_out_collector.sv
// Directed bench for aes_out_collector: inputs driven and outputs sampled on the falling edge.
module tb_aes_out_collector;

    logic         clk;
    logic         rst;
    logic [7:0]   d_in;
    logic         d_vld;
    logic [127:0] blk_out;
    logic         blk_vld;
    logic         blk_rdy;
    logic         busy;
    logic         overflow;
    logic         clr_ovf;
    logic [1:0]   level;

    int n_chk  = 0;
    int n_pass = 0;

    aes_out_collector #(.NBYTES(16), .BW(8), .DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .d_vld    (d_vld),
        .blk_out  (blk_out),
        .blk_vld  (blk_vld),
        .blk_rdy  (blk_rdy),
        .busy     (busy),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [127:0] mk(input logic [7:0] base);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = base + 8'(i);
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sixteen bytes base..base+15 starting at a d_vld rising edge; d_vld is low for
    // byte indices in [lo_from, lo_to). rdy_last raises blk_rdy in the push cycle.
    task automatic feed(input logic [7:0] base, input int lo_from, input int lo_to, input bit rdy_last);
        for (int k = 0; k < 16; k++) begin
            d_in  = base + 8'(k);
            d_vld = (k == 0) ? 1'b1 : !(k >= lo_from && k < lo_to);
            if (rdy_last && k == 15) blk_rdy = 1'b1;
            @(negedge clk);
        end
        d_vld = 1'b0;
        if (rdy_last) blk_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b0; d_in = '0; d_vld = 1'b0; blk_rdy = 1'b0; clr_ovf = 1'b0;
        #12;
        check("rst_blk_vld", blk_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_level", level, 0);
        check("rst_blk_out", blk_out, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Single block, consumer always ready
        blk_rdy = 1'b1;
        feed(8'h00, 16, 16, 1'b0);
        check("t1_vld", blk_vld, 1);
        check("t1_blk", blk_out, 128'h000102030405060708090A0B0C0D0E0F);
        check("t1_level", level, 1);
        check("t1_busy", busy, 0);
        @(negedge clk);
        check("t1_vld_gone", blk_vld, 0);
        check("t1_level0", level, 0);
        check("t1_ovf", overflow, 0);
        blk_rdy = 1'b0;

        // Back-pressure and overflow
        idle(1);
        feed(8'h10, 16, 16, 1'b0);
        check("t2_level1", level, 1);
        idle(1);
        feed(8'h20, 16, 16, 1'b0);
        check("t2_level2", level, 2);
        check("t2_no_ovf", overflow, 0);
        idle(1);
        feed(8'h30, 16, 16, 1'b0);
        check("t2_level_full", level, 2);
        check("t2_ovf", overflow, 1);
        check("t2_head0", blk_out, mk(8'h10));
        blk_rdy = 1'b1;
        @(negedge clk);
        check("t2_head1", blk_out, mk(8'h20));
        check("t2_lvl_pop1", level, 1);
        @(negedge clk);
        check("t2_lvl_pop2", level, 0);
        @(negedge clk);
        check("t2_rdy_empty", level, 0);
        check("t2_ovf_sticky", overflow, 1);
        blk_rdy = 1'b0;
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("t2_ovf_clr", overflow, 0);

        // Full with a pop in the push cycle
        feed(8'h40, 16, 16, 1'b0);
        idle(1);
        feed(8'h50, 16, 16, 1'b0);
        check("t3_full", level, 2);
        idle(1);
        feed(8'h60, 16, 16, 1'b1);
        check("t3_level", level, 2);
        check("t3_no_ovf", overflow, 0);
        check("t3_head", blk_out, mk(8'h50));
        blk_rdy = 1'b1;
        @(negedge clk);
        check("t3_next", blk_out, mk(8'h60));
        @(negedge clk);
        check("t3_drained", level, 0);
        blk_rdy = 1'b0;

        // d_vld drops at T+5 and re-rises at T+8
        feed(8'h70, 5, 8, 1'b0);
        check("t4_level", level, 1);
        check("t4_blk", blk_out, mk(8'h70));
        idle(10);
        check("t4_no_retrig", level, 1);
        check("t4_busy", busy, 0);
        blk_rdy = 1'b1;
        @(negedge clk);
        blk_rdy = 1'b0;
        check("t4_drained", level, 0);

        // Async reset mid-collection with FIFO full and overflow set
        feed(8'h80, 16, 16, 1'b0);
        idle(1);
        feed(8'h90, 16, 16, 1'b0);
        idle(1);
        feed(8'hE0, 16, 16, 1'b0);
        check("t5_pre_ovf", overflow, 1);
        idle(1);
        for (int k = 0; k < 7; k++) begin
            d_in  = 8'hF0 + 8'(k);
            d_vld = 1'b1;
            @(negedge clk);
        end
        check("t5_busy_pre", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_vld", blk_vld, 0);
        check("t5_level", level, 0);
        check("t5_ovf", overflow, 0);
        check("t5_blk_out", blk_out, 0);
        @(negedge clk);
        rst = 1'b1;
        d_vld = 1'b0;
        idle(2);
        feed(8'hA0, 16, 16, 1'b0);
        check("t5_clean_blk", blk_out, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        check("t5_clean_lvl", level, 1);
        blk_rdy = 1'b1;
        @(negedge clk);
        blk_rdy = 1'b0;
        check("t5_drained", level, 0);

        // Back-to-back: next edge the cycle after completion
        idle(1);
        feed(8'hB0, 15, 16, 1'b0);
        feed(8'hC0, 16, 16, 1'b0);
        check("t6_level", level, 2);
        check("t6_ovf", overflow, 0);
        check("t6_head", blk_out, mk(8'hB0));
        blk_rdy = 1'b1;
        @(negedge clk);
        check("t6_next", blk_out, mk(8'hC0));
        check("t6_lvl1", level, 1);
        @(negedge clk);
        check("t6_lvl0", level, 0);
        blk_rdy = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
